// File: rtl/cavlc_pkg.sv
// Shared widths and types for the CAVLC bitstream front end.
package cavlc_pkg;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int LVL_W  = 7;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BUF_W-1:0]  buf_t;
  typedef logic [LVL_W-1:0]  lvl_t;
endpackage

// File: rtl/cavlc_bit_merge.sv
// Combinational shift/merge datapath: drops consumed bits and appends an
// accepted word directly below the remaining valid bits.
import cavlc_pkg::*;

module cavlc_bit_merge (
  input  logic [63:0] i_buf,
  input  logic [6:0]  i_level,
  input  logic [4:0]  i_shift,
  input  logic [31:0] i_in_data,
  input  logic        i_accept,
  output logic [63:0] o_buf_next,
  output logic [6:0]  o_level_next
);

  buf_t w_shifted;
  buf_t w_word_aligned;
  lvl_t w_remain;

  // The caller guarantees i_shift <= i_level, so w_remain never wraps.
  assign w_remain       = i_level - lvl_t'(i_shift);
  assign w_shifted      = i_buf << i_shift;
  assign w_word_aligned = {i_in_data, 32'b0} >> w_remain;

  always_comb begin
    o_buf_next   = w_shifted;
    o_level_next = w_remain;
    if (i_accept) begin
      o_buf_next   = w_shifted | w_word_aligned;
      o_level_next = w_remain + lvl_t'(WORD_W);
    end
  end

endmodule

// File: rtl/cavlc_bitstream_shifter.sv
// 64-bit MSB-aligned bit buffer feeding a 32-bit look-ahead window to the
// CAVLC decode units; consumes 0..31 bits per cycle.
import cavlc_pkg::*;

module cavlc_bitstream_shifter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_flush,
  input  logic        i_shift_en,
  input  logic [4:0]  i_num_shift,
  output logic [31:0] o_window,
  output logic        o_barrel_shifter_ready,
  output logic [6:0]  o_fill_level,
  output logic [31:0] o_bit_count,
  output logic        o_shift_err
);

  buf_t         r_buf;
  lvl_t         r_fill;
  logic [31:0]  r_bit_count;
  logic         r_shift_err;

  logic [4:0]   w_shift_req;
  logic         w_shift_illegal;
  logic [4:0]   w_shift;
  logic         w_accept;
  buf_t         w_buf_next;
  lvl_t         w_fill_next;

  assign w_shift_req     = i_shift_en ? i_num_shift : 5'd0;
  assign w_shift_illegal = lvl_t'(w_shift_req) > r_fill;
  // An over-long shift is dropped entirely rather than truncated.
  assign w_shift         = w_shift_illegal ? 5'd0 : w_shift_req;

  assign o_in_ready = !i_reset && !i_flush && (r_fill <= lvl_t'(WORD_W));
  assign w_accept   = i_in_valid && o_in_ready;

  cavlc_bit_merge u_merge (
    .i_buf        (r_buf),
    .i_level      (r_fill),
    .i_shift      (w_shift),
    .i_in_data    (i_in_data),
    .i_accept     (w_accept),
    .o_buf_next   (w_buf_next),
    .o_level_next (w_fill_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_buf       <= '0;
      r_fill      <= '0;
      r_bit_count <= '0;
      r_shift_err <= 1'b0;
    end else begin
      r_buf       <= w_buf_next;
      r_fill      <= w_fill_next;
      r_bit_count <= r_bit_count + {27'd0, w_shift};
      r_shift_err <= r_shift_err | w_shift_illegal;
    end
  end

  assign o_window               = r_buf[63:32];
  assign o_barrel_shifter_ready = r_fill >= lvl_t'(WORD_W);
  assign o_fill_level           = r_fill;
  assign o_bit_count            = r_bit_count;
  assign o_shift_err            = r_shift_err;

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Directed vector table plus randomized run against a bit-queue model.
module tb_cavlc_bitstream_shifter;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, shift_en;
  logic [31:0] in_data;
  logic [4:0]  num_shift;
  logic        in_ready, bs_ready, shift_err;
  logic [31:0] window, bit_count;
  logic [6:0]  fill_level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cavlc_bitstream_shifter dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_in_data              (in_data),
    .i_in_valid             (in_valid),
    .o_in_ready             (in_ready),
    .i_flush                (flush),
    .i_shift_en             (shift_en),
    .i_num_shift            (num_shift),
    .o_window               (window),
    .o_barrel_shifter_ready (bs_ready),
    .o_fill_level           (fill_level),
    .o_bit_count            (bit_count),
    .o_shift_err            (shift_err)
  );

  typedef struct {
    logic        rst, fl, vl;
    logic [31:0] d;
    logic        se;
    logic [4:0]  ns;
    logic        e_inrdy;
    logic [31:0] e_win;
    logic [6:0]  e_fill;
    logic [31:0] e_bc;
    logic        e_err;
  } vec_t;

  vec_t vecs[22];

  // Reference model: the stream as an ordered queue of bits, oldest first.
  bit          mq[$];
  logic [31:0] m_bc;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_window();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++)
      if (i < mq.size()) w[31-i] = mq[i];
    return w;
  endfunction

  function automatic logic m_in_ready(input logic r, input logic f);
    return !r && !f && (mq.size() <= 32);
  endfunction

  task automatic m_step(input logic r, input logic f, input logic v, input logic [31:0] d,
                        input logic se, input logic [4:0] ns);
    logic acc;
    int   s;
    acc = v && m_in_ready(r, f);
    if (r || f) begin
      mq.delete();
      m_bc  = 0;
      m_err = 0;
    end else begin
      s = se ? int'(ns) : 0;
      if (s > mq.size()) begin
        m_err = 1;
        s = 0;
      end
      for (int i = 0; i < s; i++) void'(mq.pop_front());
      if (acc) for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
      m_bc = m_bc + 32'(s);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic se, input logic [4:0] ns);
    reset = r; flush = f; in_valid = v; in_data = d; shift_en = se; num_shift = ns;
  endtask

  task automatic set_v(input int i, input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic se, input logic [4:0] ns,
                       input logic ei, input logic [31:0] ew, input logic [6:0] ef,
                       input logic [31:0] eb, input logic ee);
    vecs[i] = '{rst:r, fl:f, vl:v, d:d, se:se, ns:ns,
                e_inrdy:ei, e_win:ew, e_fill:ef, e_bc:eb, e_err:ee};
  endtask

  initial begin
    //       rst fl vl data          se ns   inrdy window        fill bc    err
    set_v( 0, 1, 0, 0, 32'h0,        0, 0,  0, 32'h00000000, 0,  0,  0);
    set_v( 1, 0, 0, 1, 32'hDEADBEEF, 0, 0,  1, 32'hDEADBEEF, 32, 0,  0);
    set_v( 2, 0, 0, 1, 32'h12345678, 0, 0,  1, 32'hDEADBEEF, 64, 0,  0);
    set_v( 3, 0, 0, 1, 32'hFFFFFFFF, 1, 4,  0, 32'hEADBEEF1, 60, 4,  0);
    set_v( 4, 0, 0, 0, 32'h0,        1, 28, 0, 32'h12345678, 32, 32, 0);
    set_v( 5, 0, 1, 1, 32'h55555555, 1, 5,  0, 32'h00000000, 0,  0,  0);
    set_v( 6, 0, 0, 1, 32'hDEADBEEF, 0, 0,  1, 32'hDEADBEEF, 32, 0,  0);
    set_v( 7, 0, 0, 1, 32'hCAFEF00D, 1, 16, 1, 32'hBEEFCAFE, 48, 16, 0);
    set_v( 8, 0, 0, 1, 32'h11111111, 1, 16, 0, 32'hCAFEF00D, 32, 32, 0);
    set_v( 9, 0, 0, 1, 32'hAAAAAAAA, 0, 0,  1, 32'hCAFEF00D, 64, 32, 0);
    set_v(10, 0, 0, 0, 32'h0,        1, 0,  0, 32'hCAFEF00D, 64, 32, 0);
    set_v(11, 0, 0, 1, 32'h99999999, 1, 31, 0, 32'hD5555555, 33, 63, 0);
    set_v(12, 0, 0, 0, 32'h0,        1, 1,  0, 32'hAAAAAAAA, 32, 64, 0);
    set_v(13, 0, 0, 0, 32'h0,        0, 0,  1, 32'hAAAAAAAA, 32, 64, 0);
    set_v(14, 0, 0, 1, 32'h12345678, 1, 31, 1, 32'h091A2B3C, 33, 95, 0);
    set_v(15, 0, 0, 0, 32'h0,        1, 25, 0, 32'h78000000, 8, 120, 0);
    set_v(16, 0, 0, 0, 32'h0,        1, 12, 1, 32'h78000000, 8, 120, 1);
    set_v(17, 0, 0, 0, 32'h0,        0, 0,  1, 32'h78000000, 8, 120, 1);
    set_v(18, 0, 1, 0, 32'h0,        0, 0,  0, 32'h00000000, 0,  0,  0);
    set_v(19, 0, 0, 1, 32'h0F0F0F0F, 0, 0,  1, 32'h0F0F0F0F, 32, 0,  0);
    set_v(20, 1, 0, 1, 32'h33333333, 1, 3,  0, 32'h00000000, 0,  0,  0);
    set_v(21, 0, 0, 1, 32'h87654321, 0, 0,  1, 32'h87654321, 32, 0,  0);

    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].vl, vecs[i].d, vecs[i].se, vecs[i].ns);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_inrdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d window", i), window, vecs[i].e_win);
      chk($sformatf("v%0d fill", i), 32'(fill_level), 32'(vecs[i].e_fill));
      chk($sformatf("v%0d ready", i), 32'(bs_ready), 32'(vecs[i].e_fill >= 32));
      chk($sformatf("v%0d bit_count", i), bit_count, vecs[i].e_bc);
      chk($sformatf("v%0d shift_err", i), 32'(shift_err), 32'(vecs[i].e_err));
    end

    // Randomized run; model starts from a reset.
    mq.delete(); m_bc = 0; m_err = 0;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      logic r, f, v, se;
      logic [31:0] d;
      logic [4:0] ns;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 79) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      se = ($urandom_range(0, 2) != 0);
      ns = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
      drive(r, f, v, d, se, ns);
      #1;
      chk("rnd in_ready", 32'(in_ready), 32'(m_in_ready(r, f)));
      m_step(r, f, v, d, se, ns);
      @(posedge clk); #1;
      chk("rnd window", window, m_window());
      chk("rnd fill", 32'(fill_level), 32'(mq.size()));
      chk("rnd ready", 32'(bs_ready), 32'(mq.size() >= 32));
      chk("rnd bit_count", bit_count, m_bc);
      chk("rnd shift_err", 32'(shift_err), 32'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
